// File: rtl/instr_fetch_if.sv
// Fetch-unit bundle: I-cache request/response, decode-side instruction stream and redirect.
interface instr_fetch_if;
  logic        ic_req_valid;
  logic [31:0] ic_req_addr;
  logic        ic_req_ready;
  logic        ic_resp_valid;
  logic [31:0] ic_resp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output ic_req_valid, ic_req_addr,
    input  ic_req_ready, ic_resp_valid, ic_resp_data,
    output inst_valid, inst, inst_pc,
    input  inst_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  ic_req_valid, ic_req_addr,
    output ic_req_ready, ic_resp_valid, ic_resp_data,
    input  inst_valid, inst, inst_pc,
    output inst_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/instr_fetch.sv
// RV32 instruction-fetch front end: sequential PC generation, I-cache request handling,
// redirect with stale-response drop, and a small {pc, inst} FIFO toward decode.
`default_nettype none

module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  wire logic   clk,
  input  wire logic   reset,
  instr_fetch_if.master bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   fifo_pc_q   [DEPTH];
  logic [31:0]   fifo_inst_q [DEPTH];

  logic        redir;
  logic [31:0] redir_pc;
  logic        req_valid;
  logic        accept;
  logic        push;
  logic [31:0] push_pc;
  logic        pop;
  logic        head_valid;
  logic        unused_rpc_lsbs;

  assign redir           = bus.redirect_valid;
  assign redir_pc        = {bus.redirect_pc[31:2], 2'b00};
  assign unused_rpc_lsbs = ^bus.redirect_pc[1:0];

  // In WAIT/DRAIN the request stays up: the cache keeps using the address through its miss.
  assign req_valid = (state_q == S_FETCH) ? ((count_q < FULL) && !redir) : 1'b1;
  assign accept    = (state_q == S_FETCH) && req_valid && bus.ic_req_ready;

  assign bus.ic_req_valid = req_valid && !reset;
  assign bus.ic_req_addr  = (state_q == S_FETCH) ? pc_q : req_addr_q;

  assign head_valid     = (count_q != '0) && !redir;
  assign pop            = head_valid && bus.inst_ready;
  assign bus.inst_valid = head_valid;
  assign bus.inst       = fifo_inst_q[rd_ptr_q];
  assign bus.inst_pc    = fifo_pc_q[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    push       = 1'b0;
    push_pc    = pc_q;
    case (state_q)
      S_FETCH: begin
        if (redir) begin
          pc_d = redir_pc;
        end else if (accept) begin
          if (bus.ic_resp_valid) begin
            push    = 1'b1;
            push_pc = pc_q;
            pc_d    = pc_q + 32'd4;
          end else begin
            req_addr_d = pc_q;
            state_d    = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (redir) begin
          pc_d    = redir_pc;
          state_d = bus.ic_resp_valid ? S_FETCH : S_DRAIN;
        end else if (bus.ic_resp_valid) begin
          push    = 1'b1;
          push_pc = req_addr_q;
          pc_d    = req_addr_q + 32'd4;
          state_d = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (redir) begin
          pc_d = redir_pc;
        end
        if (bus.ic_resp_valid) begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redir) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset; validity is tracked entirely by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]   <= push_pc;
      fifo_inst_q[wr_ptr_q] <= bus.ic_resp_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: reference model + scoreboard, a vector table and hand sequences.
module tb_instr_fetch;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] KEY = 32'hA5A5_A5A5;
  localparam int          DEP = 4;

  logic clk;
  logic reset;

  instr_fetch_if bus ();

  instr_fetch #(.RESET_PC(RPC), .DEPTH(DEP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    bit          rdy;
    bit          exp_rv;
    logic [31:0] exp_addr;
    bit          exp_iv;
  } vec_t;

  exp_t sb[$];

  int n_total = 0;
  int n_pass  = 0;

  // reference model state
  logic [31:0] exp_pc;
  logic [31:0] lock_addr;
  bit          outstanding;
  bit          stale;

  // values observed in the most recent drive() call
  logic        obs_rv, obs_iv;
  logic [31:0] obs_addr, obs_ipc, obs_inst;
  int          n_obs_pops;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic model_init();
    sb.delete();
    exp_pc      = RPC;
    lock_addr   = RPC;
    outstanding = 1'b0;
    stale       = 1'b0;
  endtask

  task automatic clear_inputs();
    bus.ic_req_ready   = 1'b1;
    bus.ic_resp_valid  = 1'b0;
    bus.ic_resp_data   = 32'h0;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
  endtask

  // Holds reset for two edges, checks outputs, releases on a falling edge.
  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset_req_valid", {31'b0, bus.ic_req_valid}, 32'h0);
    check("reset_inst_valid", {31'b0, bus.inst_valid}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    model_init();
  endtask

  // One cycle: drive inputs at the falling edge, check against the model, play the cache, advance.
  task automatic drive(input bit hit, input bit resp_f, input bit rdy, input bit crdy,
                       input bit redir, input logic [31:0] rpc);
    bit   erv, eiv, resp;
    exp_t e;
    bus.inst_ready     = rdy;
    bus.ic_req_ready   = crdy;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.ic_resp_valid  = 1'b0;
    bus.ic_resp_data   = 32'h0;
    #1;
    obs_rv   = bus.ic_req_valid;
    obs_addr = bus.ic_req_addr;
    obs_iv   = bus.inst_valid;
    obs_ipc  = bus.inst_pc;
    obs_inst = bus.inst;

    erv = outstanding ? 1'b1 : ((sb.size() < DEP) && !redir);
    eiv = (sb.size() != 0) && !redir;
    check("req_valid", {31'b0, obs_rv}, {31'b0, erv});
    if (erv) check("req_addr", obs_addr, outstanding ? lock_addr : exp_pc);
    check("inst_valid", {31'b0, obs_iv}, {31'b0, eiv});
    if (obs_iv && rdy) n_obs_pops++;
    if (eiv && rdy) begin
      e = sb.pop_front();
      check("inst_pc", obs_ipc, e.pc);
      check("inst", obs_inst, e.data);
    end

    resp = resp_f || (hit && erv);
    bus.ic_resp_valid = resp;
    bus.ic_resp_data  = obs_addr ^ KEY;

    if (redir) begin
      sb.delete();
      if (outstanding) begin
        if (resp) begin
          outstanding = 1'b0;
          stale       = 1'b0;
        end else begin
          stale = 1'b1;
        end
      end
      exp_pc = {rpc[31:2], 2'b00};
    end else if (outstanding) begin
      if (resp) begin
        if (!stale) begin
          sb.push_back('{pc: lock_addr, data: lock_addr ^ KEY});
          exp_pc = lock_addr + 32'd4;
        end
        outstanding = 1'b0;
        stale       = 1'b0;
      end
    end else if (erv && crdy) begin
      if (resp) begin
        sb.push_back('{pc: exp_pc, data: exp_pc ^ KEY});
        exp_pc = exp_pc + 32'd4;
      end else begin
        outstanding = 1'b1;
        lock_addr   = exp_pc;
      end
    end
    @(negedge clk);
  endtask

  vec_t fill_tbl[8];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    clear_inputs();
    model_init();

    // Streaming hits with decode always ready: one instruction per cycle.
    do_reset();
    n_obs_pops = 0;
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    check("stream_pop_count", n_obs_pops, 32'd7);

    // Decode stalled: FIFO fills after four requests, one pop frees one slot.
    fill_tbl[0] = '{rdy: 1'b0, exp_rv: 1'b1, exp_addr: 32'h100, exp_iv: 1'b0};
    fill_tbl[1] = '{rdy: 1'b0, exp_rv: 1'b1, exp_addr: 32'h104, exp_iv: 1'b1};
    fill_tbl[2] = '{rdy: 1'b0, exp_rv: 1'b1, exp_addr: 32'h108, exp_iv: 1'b1};
    fill_tbl[3] = '{rdy: 1'b0, exp_rv: 1'b1, exp_addr: 32'h10C, exp_iv: 1'b1};
    fill_tbl[4] = '{rdy: 1'b0, exp_rv: 1'b0, exp_addr: 32'h0,   exp_iv: 1'b1};
    fill_tbl[5] = '{rdy: 1'b1, exp_rv: 1'b0, exp_addr: 32'h0,   exp_iv: 1'b1};
    fill_tbl[6] = '{rdy: 1'b0, exp_rv: 1'b1, exp_addr: 32'h110, exp_iv: 1'b1};
    fill_tbl[7] = '{rdy: 1'b0, exp_rv: 1'b0, exp_addr: 32'h0,   exp_iv: 1'b1};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, fill_tbl[i].rdy, 1'b1, 1'b0, 32'h0);
      check("fill_req_valid", {31'b0, obs_rv}, {31'b0, fill_tbl[i].exp_rv});
      if (fill_tbl[i].exp_rv) check("fill_req_addr", obs_addr, fill_tbl[i].exp_addr);
      check("fill_inst_valid", {31'b0, obs_iv}, {31'b0, fill_tbl[i].exp_iv});
    end

    // Miss on 0x200 answered three cycles later; address held even with ready low.
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h200);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("miss_hold_addr", obs_addr, 32'h200);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    check("miss_inst_pc", obs_ipc, 32'h200);

    // Redirect to 0x403 while waiting on 0x200: stale response dropped, refetch at 0x400.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h200);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h403);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    check("drain_hold_addr", obs_addr, 32'h200);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    check("redir_next_addr", obs_addr, 32'h400);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    check("redir_inst_pc", obs_ipc, 32'h400);

    // Redirect, response and pop all in one cycle while waiting with a non-empty FIFO.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h600);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    check("flush_inst_valid", {31'b0, obs_iv}, 32'h0);
    check("flush_next_addr", obs_addr, 32'h600);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

    // Asynchronous reset in the middle of a miss with three buffered entries.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    #2 reset = 1'b1;
    #1;
    check("async_rst_req_valid", {31'b0, bus.ic_req_valid}, 32'h0);
    check("async_rst_inst_valid", {31'b0, bus.inst_valid}, 32'h0);
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    check("restart_addr", obs_addr, RPC);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
